audio_codec_slave: RTL and testbench

Codec-side end of the 16-bit left-justified serial audio link. The block takes the master's BCLK, LRCK and DACDAT pins, runs entirely on the system clock and deserializes each left/right DAC frame into parallel samples. It also serializes parallel ADC samples onto ADCDAT. It serves as the bench/loopback partner for the audio master and as the codec stand-in on boards without a hardware codec.

---
 rtl/audio_codec_slave.sv | 183 ++++++++++++++++++
 tb/tb_audio_codec_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_slave.sv
// audio_codec_slave: codec-side endpoint of a 16-bit left-justified serial audio link, all on iCLK_18_4.
// Define AUDIO_SLAVE_FRAME_CHECK_EN to report channel halves cut short by an early LRCK edge.
module audio_codec_slave #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST_N,
  input  logic                  iAUD_BCLK,
  input  logic                  iAUD_LRCK,
  input  logic                  iAUD_DACDAT,
  output logic                  oAUD_ADCDAT,
  input  logic [DATA_WIDTH-1:0] iADC_L,
  input  logic [DATA_WIDTH-1:0] iADC_R,
  output logic                  oADC_REQ,
  output logic [DATA_WIDTH-1:0] oDAC_L,
  output logic [DATA_WIDTH-1:0] oDAC_R,
  output logic                  oDAC_VALID,
  output logic                  oFRAME_ERR
);

  typedef enum logic [1:0] {ST_WAIT, ST_SHIFT, ST_FULL} rx_state_e;
  localparam logic [4:0] BIT_LAST = 5'(DATA_WIDTH);

  // Pin pipeline bit order: [0] BCLK, [1] LRCK, [2] DACDAT.
  logic [2:0] sync1_q, sync2_q, hist_q;
  logic       bclk_rise_d, bclk_fall_d, lrck_edge_d;
  logic       bclk_rise_q, bclk_fall_q, lrck_edge_q;
  logic       lrck_lvl, dac_bit;

  rx_state_e             state_d, state_q;
  logic [4:0]            cnt_d, cnt_q;
  logic [DATA_WIDTH-1:0] rx_d, rx_q;
  logic                  chan_left_d, chan_left_q;
  logic [DATA_WIDTH-1:0] pend_l_d, pend_l_q;
  logic                  left_seen_d, left_seen_q;
  logic [DATA_WIDTH-1:0] dac_l_d, dac_l_q, dac_r_d, dac_r_q;
  logic                  dac_valid_d, dac_valid_q;
  logic                  adc_req_d, adc_req_q;
  logic [DATA_WIDTH-1:0] hold_l_d, hold_l_q, hold_r_d, hold_r_q;
  logic [DATA_WIDTH-1:0] tx_d, tx_q;
`ifdef AUDIO_SLAVE_FRAME_CHECK_EN
  logic                  frame_err_d, frame_err_q;
`endif

  // NOTE: synchronizer and history flops are left unreset so they keep tracking the pins
  // during reset; otherwise release would manufacture a false BCLK/LRCK edge.
  always_ff @(posedge iCLK_18_4) begin
    sync1_q <= {iAUD_DACDAT, iAUD_LRCK, iAUD_BCLK};
    sync2_q <= sync1_q;
    hist_q  <= sync2_q;
  end

  always_comb begin
    bclk_rise_d = sync2_q[0] & ~hist_q[0];
    bclk_fall_d = ~sync2_q[0] & hist_q[0];
    lrck_edge_d = sync2_q[1] ^ hist_q[1];
  end

  // The history flops lag by one cycle, which lines them up with the registered edge flags.
  assign lrck_lvl = hist_q[1];
  assign dac_bit  = hist_q[2];

  always_comb begin
    // NOTE: every _d takes its hold value first so no latch is inferred; this block uses
    // blocking assignments, the register block below uses non-blocking only.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    chan_left_d = chan_left_q;
    pend_l_d    = pend_l_q;
    left_seen_d = left_seen_q;
    dac_l_d     = dac_l_q;
    dac_r_d     = dac_r_q;
    dac_valid_d = 1'b0;
    adc_req_d   = 1'b0;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    tx_d        = tx_q;
`ifdef AUDIO_SLAVE_FRAME_CHECK_EN
    frame_err_d = 1'b0;
`endif

    if (lrck_edge_q) begin
      if (state_q == ST_SHIFT) begin
        left_seen_d = 1'b0;
`ifdef AUDIO_SLAVE_FRAME_CHECK_EN
        frame_err_d = 1'b1;
`endif
      end
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      rx_d        = '0;
      chan_left_d = lrck_lvl;
    end

    // Tested against state_d so a rising BCLK coincident with LRCK becomes the new half's MSB.
    if (bclk_rise_q && state_d == ST_SHIFT) begin
      rx_d  = {rx_d[DATA_WIDTH-2:0], dac_bit};
      cnt_d = cnt_d + 5'd1;
      if (cnt_d == BIT_LAST) begin
        state_d = ST_FULL;
        if (chan_left_d) begin
          pend_l_d    = rx_d;
          left_seen_d = 1'b1;
        end else if (left_seen_d) begin
          dac_l_d     = pend_l_q;
          dac_r_d     = rx_d;
          dac_valid_d = 1'b1;
          left_seen_d = 1'b0;
        end
      end
    end

    if (lrck_edge_q) begin
      if (lrck_lvl) begin
        hold_l_d  = iADC_L;
        hold_r_d  = iADC_R;
        adc_req_d = 1'b1;
        tx_d      = iADC_L;
      end else begin
        tx_d = hold_r_q;
      end
    end else if (bclk_fall_q) begin
      tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge iCLK_18_4) begin
    if (!iRST_N) begin
      bclk_rise_q <= 1'b0;
      bclk_fall_q <= 1'b0;
      lrck_edge_q <= 1'b0;
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      rx_q        <= '0;
      chan_left_q <= 1'b0;
      pend_l_q    <= '0;
      left_seen_q <= 1'b0;
      dac_l_q     <= '0;
      dac_r_q     <= '0;
      dac_valid_q <= 1'b0;
      adc_req_q   <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      tx_q        <= '0;
`ifdef AUDIO_SLAVE_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      bclk_rise_q <= bclk_rise_d;
      bclk_fall_q <= bclk_fall_d;
      lrck_edge_q <= lrck_edge_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      chan_left_q <= chan_left_d;
      pend_l_q    <= pend_l_d;
      left_seen_q <= left_seen_d;
      dac_l_q     <= dac_l_d;
      dac_r_q     <= dac_r_d;
      dac_valid_q <= dac_valid_d;
      adc_req_q   <= adc_req_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      tx_q        <= tx_d;
`ifdef AUDIO_SLAVE_FRAME_CHECK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign oAUD_ADCDAT = tx_q[DATA_WIDTH-1];
  assign oADC_REQ    = adc_req_q;
  assign oDAC_L      = dac_l_q;
  assign oDAC_R      = dac_r_q;
  assign oDAC_VALID  = dac_valid_q;
`ifdef AUDIO_SLAVE_FRAME_CHECK_EN
  assign oFRAME_ERR  = frame_err_q;
`else
  assign oFRAME_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_codec_slave.sv
// Bench for audio_codec_slave: a behavioural link master drives randomized frames; a
// frame-level reference model queues expected outputs that a monitor pops and compares.
module tb_audio_codec_slave;

  localparam int DW    = 16;
  localparam int PHASE = 6;

  logic          clk;
  logic          rst_n;
  logic          aud_bclk, aud_lrck, aud_dacdat, aud_adcdat;
  logic [DW-1:0] adc_l, adc_r, dac_l, dac_r;
  logic          adc_req, dac_valid, frame_err;

  audio_codec_slave #(.DATA_WIDTH(DW)) dut (
    .iCLK_18_4   (clk),
    .iRST_N      (rst_n),
    .iAUD_BCLK   (aud_bclk),
    .iAUD_LRCK   (aud_lrck),
    .iAUD_DACDAT (aud_dacdat),
    .oAUD_ADCDAT (aud_adcdat),
    .iADC_L      (adc_l),
    .iADC_R      (adc_r),
    .oADC_REQ    (adc_req),
    .oDAC_L      (dac_l),
    .oDAC_R      (dac_r),
    .oDAC_VALID  (dac_valid),
    .oFRAME_ERR  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0, req_seen = 0;
  int exp_err = 0, exp_req = 0;
  logic [31:0] dac_exp_q[$];
  logic [31:0] dac_e;

  // Frame-level reference model state.
  bit            m_seen, m_in_half, m_open;
  logic [DW-1:0] m_pend, m_hold_l, m_hold_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every oDAC_VALID pulse and counts the other pulses.
  always @(negedge clk) begin
    if (dac_valid) begin
      if (dac_exp_q.size() == 0) begin
        check("dac_unexpected_valid", 32'(dac_valid), 32'd0);
      end else begin
        dac_e = dac_exp_q.pop_front();
        check("dac_left", 32'(dac_l), 32'(dac_e[31:16]));
        check("dac_right", 32'(dac_r), 32'(dac_e[15:0]));
      end
    end
    if (frame_err) err_seen++;
    if (adc_req) req_seen++;
  end

  task automatic pulse_reset(input int hold);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_adcdat", 32'(aud_adcdat), 32'd0);
    check("rst_dac_l", 32'(dac_l), 32'd0);
    check("rst_dac_r", 32'(dac_r), 32'd0);
    check("rst_dac_valid", 32'(dac_valid), 32'd0);
    check("rst_adc_req", 32'(adc_req), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One channel half: LRCK level lr, 16-bit word plus random filler, nbits BCLK periods.
  // simul moves the LRCK change onto the first rising BCLK; rst_at >= 0 pulses reset at that bit.
  task automatic send_half(input bit lr, input logic [DW-1:0] word, input int nbits,
                           input bit simul, input int rst_at);
    logic [31:0]   bits;
    logic [31:0]   cap;
    logic [DW-1:0] exp_adc;
    bits = {word, 16'($urandom)};
    cap  = '0;

    if (m_in_half && m_open) begin
      m_seen = 1'b0;
`ifdef AUDIO_SLAVE_FRAME_CHECK_EN
      exp_err++;
`endif
    end
    if (lr) begin
      m_hold_l = adc_l;
      m_hold_r = adc_r;
      exp_req++;
    end
    exp_adc   = lr ? m_hold_l : m_hold_r;
    m_in_half = 1'b1;
    m_open    = (nbits < DW);
    if (rst_at >= 0) begin
      m_in_half = 1'b0;
      m_open    = 1'b0;
      m_seen    = 1'b0;
      m_hold_l  = '0;
      m_hold_r  = '0;
    end else if (nbits >= DW) begin
      if (lr) begin
        m_pend = word;
        m_seen = 1'b1;
      end else if (m_seen) begin
        dac_exp_q.push_back({16'(m_pend), 16'(word)});
        m_seen = 1'b0;
      end
    end

    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      aud_bclk   = 1'b0;
      aud_dacdat = bits[31-i];
      if (i == 0 && !simul) aud_lrck = lr;
      repeat (PHASE) @(negedge clk);
      cap      = {cap[30:0], aud_adcdat};
      aud_bclk = 1'b1;
      if (i == 0 && simul) aud_lrck = lr;
      if (i == rst_at) begin
        pulse_reset(2);
        repeat (PHASE - 3) @(negedge clk);
      end else begin
        repeat (PHASE - 1) @(negedge clk);
      end
    end

    if (!simul && rst_at < 0 && nbits == 2 * DW)
      check(lr ? "adc_left_word" : "adc_right_word", cap, {16'(exp_adc), 16'h0000});
  endtask

  initial begin
    rst_n      = 1'b1;
    aud_bclk   = 1'b1;
    aud_lrck   = 1'b1;
    aud_dacdat = 1'b0;
    adc_l      = '0;
    adc_r      = '0;
    m_seen     = 1'b0;
    m_in_half  = 1'b0;
    m_open     = 1'b0;
    m_pend     = '0;
    m_hold_l   = '0;
    m_hold_r   = '0;

    @(negedge clk);
    pulse_reset(6);
    repeat (4) @(negedge clk);

    // Stream opens right-first: the orphan right half is dropped.
    adc_l = 16'($urandom);
    adc_r = 16'($urandom);
    send_half(1'b0, 16'h5555, 32, 1'b0, -1);
    send_half(1'b1, 16'hAAAA, 32, 1'b0, -1);
    send_half(1'b0, 16'h0F0F, 32, 1'b0, -1);

    adc_l = 16'h1234;
    adc_r = 16'hFEDC;
    send_half(1'b1, 16'h6000, 32, 1'b0, -1);
    send_half(1'b0, 16'hA000, 32, 1'b0, -1);

    // Left half cut short after 10 bits, then a clean frame.
    adc_l = 16'($urandom);
    adc_r = 16'($urandom);
    send_half(1'b1, 16'($urandom), 10, 1'b0, -1);
    send_half(1'b0, 16'($urandom), 32, 1'b0, -1);
    send_half(1'b1, 16'h0001, 32, 1'b0, -1);
    send_half(1'b0, 16'h8000, 32, 1'b0, -1);

    // LRCK change on the same iCLK edge as rising BCLK, MSB = 1.
    send_half(1'b1, 16'h8000 | 16'($urandom), 32, 1'b1, -1);
    send_half(1'b0, 16'h8000 | 16'($urandom), 32, 1'b1, -1);

    // Reset in the middle of a right half, then a full frame.
    adc_l = 16'($urandom);
    adc_r = 16'($urandom);
    send_half(1'b1, 16'($urandom), 32, 1'b0, -1);
    send_half(1'b0, 16'($urandom), 32, 1'b0, 8);
    send_half(1'b1, 16'($urandom), 32, 1'b0, -1);
    send_half(1'b0, 16'($urandom), 32, 1'b0, -1);

    for (int f = 0; f < 6; f++) begin
      adc_l = 16'($urandom);
      adc_r = 16'($urandom);
      send_half(1'b1, 16'($urandom), 32, 1'b0, -1);
      send_half(1'b0, 16'($urandom), 32, 1'b0, -1);
    end

    repeat (20) @(negedge clk);
    check("dac_frames_outstanding", 32'(dac_exp_q.size()), 32'd0);
    check("frame_err_pulses", 32'(err_seen), 32'(exp_err));
    check("adc_req_pulses", 32'(req_seen), 32'(exp_req));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
